// File: rtl/spi_mem_ctrl_pkg.sv
// Shared constants, state encoding and frame helpers for the SPI memory controller.
package spi_mem_ctrl_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  localparam int FRAME_LEN = 64;
  localparam int DATA_LEN  = 32;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Data bytes go out least-significant byte first, each byte MSB-first.
  function automatic logic [FRAME_LEN-1:0] build_frame(
    input logic        we,
    input logic [23:0] addr,
    input logic [31:0] wdata
  );
    logic [7:0] cmd;
    cmd = we ? SPI_CMD_WRITE : SPI_CMD_READ;
    return {cmd, addr, wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
  endfunction

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_mem_shifter.sv
// Frame shift-out register and read-data shift-in register for the SPI memory controller.
module spi_mem_shifter
  import spi_mem_ctrl_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [FRAME_LEN-1:0] i_frame,
  input  logic                 i_shift,
  input  logic                 i_sample,
  input  logic                 i_miso,
  output logic                 o_next_bit,
  output logic [DATA_LEN-1:0]  o_rx_next
);

  logic [FRAME_LEN-1:0] r_tx;
  logic [DATA_LEN-1:0]  r_rx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx <= '0;
      r_rx <= '0;
    end else begin
      if (i_load) begin
        r_tx <= i_frame;
      end else if (i_shift) begin
        r_tx <= {r_tx[FRAME_LEN-2:0], 1'b0};
      end

      if (i_load) begin
        r_rx <= '0;
      end else if (i_sample) begin
        r_rx <= o_rx_next;
      end
    end
  end

  // The controller registers MOSI itself, so it needs the bit that follows the current MSB.
  assign o_next_bit = r_tx[FRAME_LEN-2];
  assign o_rx_next  = {r_rx[DATA_LEN-2:0], i_miso};

endmodule

// File: rtl/spi_mem_ctrl.sv
// Single-lane SPI master: one word request becomes a cmd/addr/data transaction on flash or PSRAM.
//
// state    | meaning
// ST_IDLE  | waiting for a request, both chip selects high
// ST_SHIFT | 64-bit frame on the wire, two clk per bit
// ST_DONE  | one-cycle completion pulse, chip selects released
// ST_GAP   | CS_GAP cycles with both selects high, requests ignored
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int CS_GAP = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_spi_addr,
  input  logic [31:0] i_spi_wdata,
  output logic [31:0] o_spi_rdata,
  input  logic        i_spi_valid,
  output logic        o_spi_ready,
  input  logic        i_spi_we,
  input  logic        i_spi_mem_select,
  output logic        o_spi_sck,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso,
  output logic        o_spi_flash_cs_n,
  output logic        o_spi_ram_cs_n
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_phase;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_we;
  logic               r_ready;
  logic [31:0]        r_rdata;
  logic               r_sck;
  logic               r_mosi;
  logic               r_flash_cs_n;
  logic               r_ram_cs_n;

  logic [FRAME_LEN-1:0] w_frame;
  logic                 w_flash_wr;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_sample;
  logic                 w_last_bit;
  logic                 w_next_bit;
  logic [DATA_LEN-1:0]  w_rx_next;

  assign w_frame    = build_frame(i_spi_we, i_spi_addr, i_spi_wdata);
  assign w_flash_wr = !i_spi_mem_select && i_spi_we;
  assign w_load     = (r_state == ST_IDLE) && i_spi_valid && !w_flash_wr;
  assign w_last_bit = (r_bit_cnt == '0);
  assign w_shift    = (r_state == ST_SHIFT) && r_phase && !w_last_bit;
  // Only the trailing 32 bits carry read data; cmd/addr-time MISO is dropped.
  assign w_sample   = (r_state == ST_SHIFT) && r_phase && !r_we
                      && (r_bit_cnt < CNT_W'(DATA_LEN));

  spi_mem_shifter u_shifter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_frame    (w_frame),
    .i_shift    (w_shift),
    .i_sample   (w_sample),
    .i_miso     (i_spi_miso),
    .o_next_bit (w_next_bit),
    .o_rx_next  (w_rx_next)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_phase      <= 1'b0;
      r_gap_cnt    <= '0;
      r_we         <= 1'b0;
      r_ready      <= 1'b0;
      r_rdata      <= '0;
      r_sck        <= 1'b0;
      r_mosi       <= 1'b0;
      r_flash_cs_n <= 1'b1;
      r_ram_cs_n   <= 1'b1;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_spi_valid) begin
            r_we <= i_spi_we;
            if (w_flash_wr) begin
              // Flash is read-only here: complete at once without touching the pads.
              r_rdata <= '0;
              r_ready <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_bit_cnt    <= CNT_W'(FRAME_LEN - 1);
              r_phase      <= 1'b0;
              r_sck        <= 1'b0;
              r_mosi       <= w_frame[FRAME_LEN-1];
              r_flash_cs_n <= i_spi_mem_select;
              r_ram_cs_n   <= !i_spi_mem_select;
              r_state      <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (!r_phase) begin
            r_sck   <= 1'b1;
            r_phase <= 1'b1;
          end else begin
            r_sck   <= 1'b0;
            r_phase <= 1'b0;
            if (w_last_bit) begin
              r_mosi       <= 1'b0;
              r_flash_cs_n <= 1'b1;
              r_ram_cs_n   <= 1'b1;
              r_ready      <= 1'b1;
              r_rdata      <= r_we ? '0 : byte_swap32(w_rx_next);
              r_state      <= ST_DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt - 1'b1;
              r_mosi    <= w_next_bit;
            end
          end
        end
        ST_DONE: begin
          r_gap_cnt <= GAP_LOAD;
          r_state   <= ST_GAP;
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_spi_ready      = r_ready;
  assign o_spi_rdata      = r_rdata;
  assign o_spi_sck        = r_sck;
  assign o_spi_mosi       = r_mosi;
  assign o_spi_flash_cs_n = r_flash_cs_n;
  assign o_spi_ram_cs_n   = r_ram_cs_n;

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

Single-lane SPI master serving the CPU bridge's SPI memory port: turns one `spi_valid` word request into a complete SPI transaction (command, 24-bit address, 32-bit data) on either the boot flash or the external PSRAM. It sits directly downstream of the SoC base, consuming `spi_addr`/`spi_wdata`/`spi_we`/`spi_mem_select` and returning `spi_rdata`/`spi_ready`. It drives the SPI pads directly.

## Interface
- `CS_GAP`, default 2: minimum clk cycles with both chip selects high between transactions (≥1).
- `clk` in 1: system clock; sole clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `spi_addr` in 24: byte address sent verbatim on the wire.
- `spi_wdata` in 32: write word.
- `spi_rdata` out 32: read word; valid in the `spi_ready` cycle.
- `spi_valid` in 1: request; held by master until `spi_ready`.
- `spi_ready` out 1: one-cycle completion pulse.
- `spi_we` in 1: 1 = write, 0 = read.
- `spi_mem_select` in 1: 0 = flash, 1 = PSRAM.
- `spi_sck` out 1: SPI clock, mode 0, clk/2.
- `spi_mosi` out 1: serial out, MSB-first per byte.
- `spi_miso` in 1: serial in.
- `spi_flash_cs_n` out 1: flash select, active-low.
- `spi_ram_cs_n` out 1: PSRAM select, active-low.

## Operation
- States: IDLE, SHIFT, DONE, GAP.
- IDLE: on `spi_valid`=1, latch addr/wdata/we/select; frame = {cmd[7:0], addr[23:16], addr[15:8], addr[7:0], d0, d1, d2, d3}, 64 bits. cmd = 8'h02 write, 8'h03 read. d0 = wdata[7:0] … d3 = wdata[31:24] (little-endian). → SHIFT, assert selected CS.
- Flash write (`spi_mem_select`=0, `spi_we`=1): no pad activity; IDLE → DONE directly; `spi_rdata` = 0.
- SHIFT: 64-bit counter, 2 clk per bit. Phase 0: `spi_sck`=0, `spi_mosi` = current frame bit. Phase 1: `spi_sck`=1; `spi_miso` captured on the clk edge ending phase 1. After bit 63 → DONE.
- Read data: first received data byte → `spi_rdata[7:0]`, fourth → `[31:24]`; bits received during cmd/addr are discarded. On writes, `spi_rdata` = 0.
- DONE: `spi_ready`=1 for exactly one cycle, CS released, `spi_sck`=0 → GAP.
- GAP: CS_GAP cycles with both CS high, `spi_valid` ignored (covers the master's deassert cycle) → IDLE.
- Never assert both CS together; CS switches only through GAP.

## Timing
- Reset values: `spi_ready`=0, `spi_rdata`=0, `spi_sck`=0, `spi_mosi`=0, both CS_n=1; state IDLE.
- Valid sampled in IDLE at edge N → CS low from N+1; bits occupy cycles N+1..N+128; `spi_ready` high in cycle N+129 with CS high; next acceptance no earlier than N+130+CS_GAP.
- Flash write: `spi_ready` in cycle N+1.
- Reset mid-transaction: immediate return to reset values, CS high, no `spi_ready`; the in-flight request is lost.
- `spi_rdata` holds its last value until the next completed read or write.

## Structure
- Header `spi_mem_defs.vh`: opcodes `SPI_CMD_READ`=8'h03 and `SPI_CMD_WRITE`=8'h02, state encodings, frame length 64.
- One sub-module, `spi_mem_shifter`: a 64-bit load/shift-out register plus a 32-bit shift-in register, with `load`, `shift` and `sample` strobes. The FSM, bit counter, SCK phase and CS logic stay in `spi_mem_ctrl`.

## Test plan
- PSRAM write, addr 24'h012345, wdata 32'hDEADBEEF -> `spi_ram_cs_n` low for 128 cycles; MOSI bytes 02 01 23 45 EF BE AD DE; `spi_ready` at N+129; flash CS stays high.
- Flash read, addr 24'h100000; MISO model returns bytes 11 22 33 44 -> cmd 03; `spi_rdata`=32'h44332211 in the ready cycle.
- Flash write -> no SCK edges, no CS activity; `spi_ready` at N+1; `spi_rdata`=0.
- Back-to-back requests with valid held high through the ready cycle -> exactly one transaction per request; CS high for ≥CS_GAP+1 cycles between them.
- Assert `rst` at bit 30 of a read -> next cycle both CS high, SCK 0, no ready; a following read completes correctly.
- Alternate flash/PSRAM reads -> the CS lines never overlap; SCK period is 2 clk throughout.
